// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// Module   : display_pkg
// Purpose  : Shared state encoding and default timing for the display scanner.
// Revision : 1.0  initial release
// ============================================================================
package display_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BLANK1 = 3'd1,
    SHOW1  = 3'd2,
    BLANK2 = 3'd3,
    SHOW2  = 3'd4
  } scan_state_t;

  // 40000 cycles at 48 MHz gives a ~600 Hz frame with a 1% blanking gap.
  localparam int unsigned c_dwell_default = 40000;
  localparam int unsigned c_blank_default = 480;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/scan_timer.sv
`default_nettype none
// ============================================================================
// Module   : scan_timer
// Purpose  : Per-state cycle counter with clear and terminal-count flag.
// Revision : 1.0  initial release
// ============================================================================
module scan_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  // tc marks the last cycle of the current state, so the owner leaves on the next edge
  assign tc    = (r_count == (limit - WIDTH'(1)));
  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/display_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : display_scan_controller
// Purpose  : Two-digit multiplexed seven-segment scanner with blanking gaps.
// Revision : 1.0  initial release
// ============================================================================
module display_scan_controller
  import display_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = c_dwell_default,
  parameter int unsigned BLANK_CYCLES = c_blank_default
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] s1,
  input  logic [3:0] s2,
  input  logic       d1_en,
  input  logic       d2_en,
  output logic [3:0] val,
  output logic       sel,
  output logic       an1,
  output logic       an2,
  output logic       frame_tick
);

  localparam int unsigned c_cnt_w = $clog2(max_u(DWELL_CYCLES, BLANK_CYCLES) + 1);
  localparam logic [c_cnt_w-1:0] c_dwell_lim = c_cnt_w'(DWELL_CYCLES);
  localparam logic [c_cnt_w-1:0] c_blank_lim = c_cnt_w'(BLANK_CYCLES);
  localparam logic [c_cnt_w-1:0] c_dwell_m2  =
    c_cnt_w'((DWELL_CYCLES >= 32'd2) ? (DWELL_CYCLES - 32'd2) : 32'd0);

  scan_state_t        r_state;
  scan_state_t        w_next;
  logic [c_cnt_w-1:0] w_limit;
  logic [c_cnt_w-1:0] w_count;
  logic               w_tc;
  logic               w_change;
  logic               w_clear;
  logic               w_ft_next;
  logic               r_d1_lat;
  logic               r_d2_lat;

  assign w_limit  = ((r_state == BLANK1) || (r_state == BLANK2)) ? c_blank_lim : c_dwell_lim;
  assign w_change = (w_next != r_state);
  assign w_clear  = w_change || (r_state == IDLE);

  scan_timer #(
    .WIDTH (c_cnt_w)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (w_clear),
    .limit (w_limit),
    .count (w_count),
    .tc    (w_tc)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (en) w_next = BLANK1;
      BLANK1:  if (!en) w_next = IDLE; else if (w_tc) w_next = SHOW1;
      SHOW1:   if (!en) w_next = IDLE; else if (w_tc) w_next = BLANK2;
      BLANK2:  if (!en) w_next = IDLE; else if (w_tc) w_next = SHOW2;
      SHOW2:   if (!en) w_next = IDLE; else if (w_tc) w_next = BLANK1;
      default: w_next = IDLE;
    endcase
  end

  // Registered tick must be high during the final SHOW2 cycle, so predict it one edge early.
  always_comb begin
    w_ft_next = 1'b0;
    if (w_next == SHOW2) begin
      if (w_change) begin
        w_ft_next = (DWELL_CYCLES == 32'd1);
      end else begin
        w_ft_next = (DWELL_CYCLES >= 32'd2) && (w_count == c_dwell_m2);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      val        <= 4'd0;
      sel        <= 1'b0;
      an1        <= 1'b1;
      an2        <= 1'b1;
      frame_tick <= 1'b0;
      r_d1_lat   <= 1'b0;
      r_d2_lat   <= 1'b0;
    end else begin
      r_state    <= w_next;
      frame_tick <= w_ft_next;
      an1        <= ~((w_next == SHOW1) && r_d1_lat);
      an2        <= ~((w_next == SHOW2) && r_d2_lat);
      if ((w_next == BLANK1) && (r_state != BLANK1)) begin
        val      <= s1;
        sel      <= 1'b0;
        r_d1_lat <= d1_en;
      end
      if ((w_next == BLANK2) && (r_state != BLANK2)) begin
        val      <= s2;
        sel      <= 1'b1;
        r_d2_lat <= d2_en;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/display_scan_controller.md
DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

Interface
REQ-001 Parameter DWELL_CYCLES, default 40000: clk cycles each digit is lit per slot; legal range is 1 or more.
REQ-002 Parameter BLANK_CYCLES, default 480: clk cycles with both anodes off before each digit; legal range is 1 or more.
REQ-003 clk  in  1  system clock from HSOSC (48 MHz).
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 en  in  1  scan enable; low forces idle with display dark.
REQ-006 s1, s2  in  4 each  hex values for digit 1 and digit 2.
REQ-007 d1_en, d2_en  in  1 each  per-digit display enable.
REQ-008 val  out  4  registered hex value for the shared seven-segment decoder.
REQ-009 sel  out  1  registered source select: 0 = s1/digit 1, 1 = s2/digit 2.
REQ-010 an1, an2  out  1 each  registered anode drives, active-low; 1 = off.
REQ-011 frame_tick  out  1  registered one-cycle pulse at the end of each full two-digit frame.

Function
REQ-012 FSM states SHALL be: IDLE, BLANK1, SHOW1, BLANK2, SHOW2.
REQ-013 A dwell counter SHALL count cycles within the current state, SHALL clear on every state change, and SHALL be sized to $clog2(max(DWELL_CYCLES, BLANK_CYCLES)+1) bits.
REQ-014 IDLE -> BLANK1 SHALL occur on the first edge where en = 1.
REQ-015 BLANKn -> SHOWn SHALL occur after exactly BLANK_CYCLES cycles in BLANKn.
REQ-016 SHOW1 -> BLANK2 and SHOW2 -> BLANK1 SHALL occur after exactly DWELL_CYCLES cycles in the SHOW state.
REQ-017 The frame period SHALL be 2*(BLANK_CYCLES+DWELL_CYCLES) cycles.
REQ-018 On entry to BLANK1, val SHALL load s1, sel SHALL load 0, and d1_en SHALL be latched; all three are held for the whole slot.
REQ-019 On entry to BLANK2, val SHALL load s2, sel SHALL load 1, and d2_en SHALL be latched; all three are held for the whole slot.
REQ-020 an1 SHALL be 0 only while the state is SHOW1 and the latched d1_en is 1.
REQ-021 an2 SHALL be 0 only while the state is SHOW2 and the latched d2_en is 1.
REQ-022 The anodes SHALL be 1 in every other state.
REQ-023 A disabled digit SHALL still occupy its full slot, so brightness stays constant.
REQ-024 an1 and an2 SHALL never both be 0 in the same cycle.
REQ-025 A change of sel or val SHALL never coincide with a lit anode.
REQ-026 frame_tick SHALL be 1 for exactly the cycle in which the state is leaving SHOW2.
REQ-027 en = 0 in any non-IDLE state: on the next edge the state SHALL become IDLE, the counter SHALL clear, an1/an2 SHALL go to 1, frame_tick SHALL be 0, and val/sel SHALL hold.
REQ-028 Re-enabling SHALL always restart at BLANK1.
REQ-029 Changes to s1, s2, d1_en or d2_en within a slot SHALL take effect at the next entry to that digit's BLANK state.

Reset
REQ-030 reset SHALL take priority over en.
REQ-031 On reset the state SHALL be IDLE, the counter 0, an1 = an2 = 1, sel = 0, val = 0, frame_tick = 0, and the latched enables 0.
REQ-032 Reset asserted mid-SHOW SHALL darken both anodes on the same edge.

Structure
REQ-033 Package display_pkg SHALL hold the state enum typedef scan_state_t and the default DWELL/BLANK constants.
REQ-034 Sub-module scan_timer SHALL implement the dwell counter (clear input, terminal-count output, parameterised width).
REQ-035 All outputs SHALL be driven from flops; there SHALL be no combinational path from an input to an output.

Verification (DWELL_CYCLES = 4, BLANK_CYCLES = 2; cycle numbering starts at the first edge with en = 1)
REQ-036 Scenario 1: reset held 3 cycles with en = 1 -> an1 = an2 = 1, sel = 0, val = 0, frame_tick = 0 throughout.
REQ-037 Scenario 2: en = 1, s1 = 3, s2 = A, both digits enabled:
- cycles 1-2: both anodes off, sel = 0, val = 3;
- cycles 3-6: an1 = 0;
- cycles 7-8: both off, sel = 1, val = A;
- cycles 9-12: an2 = 0;
- frame_tick pulses on the cycle-12 edge;
- the pattern repeats every 12 cycles.
REQ-038 Scenario 3: as scenario 2 with d2_en = 0 -> an2 stays 1 always, an1 timing is unchanged, and the period is still 12.
REQ-039 Scenario 4: s1 changes 3 -> 7 during SHOW1 -> val stays 3 until the next BLANK1 entry, then becomes 7.
REQ-040 Scenario 5: en dropped in cycle 10 -> both anodes 1 from the next edge, FSM in IDLE; en reasserted -> BLANK1 with val = s1 two cycles before an1 = 0.
REQ-041 Scenario 6: reset asserted in cycle 4 -> both anodes 1 and all outputs at reset values on that edge.
REQ-042 All scenarios: an assertion SHALL check that an1 and an2 are never both 0, and that sel/val never change while either anode is 0.
